// File: rtl/mfe_pkg.sv
// rtl/mfe_pkg.sv - shared image geometry constants and loader state encoding for the MFE
package mfe_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int PIX_W     = 8;
  localparam int ADDR_W    = 14;
  localparam int FRAME_PIX = IMG_W * IMG_H;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_HANDOFF,
    ST_WAIT_DONE
  } ld_state_e;

endpackage

// File: rtl/mfe_frame_ctr.sv
// rtl/mfe_frame_ctr.sv - frame pixel counter shared by the load and pad paths
module mfe_frame_ctr #(
  parameter int ADDR_W    = 14,
  parameter int FRAME_PIX = 16384
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              tc_o
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(FRAME_PIX - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Saturates on the last pixel so a frame can never wrap onto address 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mfe_img_loader.sv
// rtl/mfe_img_loader.sv - streams one frame into the image SRAM and hands it to the MFE
// Optional frame checksum outputs under `define MFE_IMG_LOADER_CHECKSUM_EN.
module mfe_img_loader
  import mfe_pkg::*;
#(
  parameter int IMG_W  = mfe_pkg::IMG_W,
  parameter int IMG_H  = mfe_pkg::IMG_H,
  parameter int PIX_W  = mfe_pkg::PIX_W,
  parameter int ADDR_W = mfe_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              mem_wen,
  output logic              mfe_ready,
  input  logic              mfe_busy,
  output logic              err_short,
`ifdef MFE_IMG_LOADER_CHECKSUM_EN
  output logic                    err_long,
  output logic [PIX_W+ADDR_W-1:0] frame_sum,
  output logic                    frame_sum_vld
`else
  output logic              err_long
`endif
);

  localparam int NPIX = IMG_W * IMG_H;

  ld_state_e         state_q;
  logic              rdy_q, wen_q, mfe_ready_q, err_short_q, err_long_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  wdata_q;
  logic [ADDR_W-1:0] cnt;
  logic              tc, cnt_clr, cnt_inc, acc, filling, enter_handoff;

  // rdy_q is zero for the first cycle out of reset; the busy term keeps
  // a new frame from starting while the MFE still owns the SRAM.
  assign s_ready = rdy_q && !((state_q == ST_IDLE) && mfe_busy);
  assign acc     = s_valid && s_ready;
  assign filling = (state_q == ST_IDLE) || (state_q == ST_LOAD);

  always_comb begin
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    enter_handoff = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        cnt_inc       = acc;
        enter_handoff = acc && tc;
      end
      ST_PAD: begin
        cnt_inc       = 1'b1;
        enter_handoff = tc;
      end
      ST_WAIT_DONE: cnt_clr = !mfe_busy;
      default: ;
    endcase
  end

  mfe_frame_ctr #(
    .ADDR_W   (ADDR_W),
    .FRAME_PIX(NPIX)
  ) u_ctr (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mfe_ready_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          rdy_q <= 1'b1;
          if (acc) begin
            wen_q   <= 1'b1;
            addr_q  <= cnt;
            wdata_q <= s_data;
            if (tc) begin
              state_q <= ST_HANDOFF;
              rdy_q   <= 1'b0;
              if (!s_last) err_long_q <= 1'b1;
            end else if (s_last) begin
              state_q     <= ST_PAD;
              rdy_q       <= 1'b0;
              err_short_q <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_PAD: begin
          wen_q   <= 1'b1;
          addr_q  <= cnt;
          wdata_q <= '0;
          if (tc) state_q <= ST_HANDOFF;
        end
        // mfe_ready rises one cycle into HANDOFF so it never overlaps the final write.
        ST_HANDOFF: begin
          if (mfe_ready_q && mfe_busy) begin
            mfe_ready_q <= 1'b0;
            state_q     <= ST_WAIT_DONE;
          end else begin
            mfe_ready_q <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!mfe_busy) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wen   = wen_q;
  assign mfe_ready = mfe_ready_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

`ifdef MFE_IMG_LOADER_CHECKSUM_EN
  logic [PIX_W+ADDR_W-1:0] sum_q;
  logic                    sum_vld_q;

  // Pad writes add zero, so only accepted beats feed the accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
    end else begin
      sum_vld_q <= enter_handoff;
      if (cnt_clr) begin
        sum_q <= '0;
      end else if (filling && acc) begin
        sum_q <= sum_q + (PIX_W+ADDR_W)'(s_data);
      end
    end
  end

  assign frame_sum     = sum_q;
  assign frame_sum_vld = sum_vld_q;
`endif

endmodule
